// File: rtl/timebase_gen.sv
// timebase_gen: one prescaler chain (tick_us / tick_ms strobes, no derived
// clocks) plus N_CH programmable countdown channels. Each channel runs
// one-shot or periodic on the us or ms base and raises a one-cycle pulse and a
// sticky flag on expiry.
//
// Optional feature: define TIMEBASE_SQUARE_EN to add the timer_us / timer_ms
// square-wave outputs, which toggle on every tick_us / tick_ms strobe.
module timebase_gen #(
  parameter int unsigned  CLK_HZ   = 50_000_000,
  parameter int unsigned  N_CH     = 4,
  parameter int unsigned  PERIOD_W = 16,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                CLK_50M,
  input  logic                RST,
  output logic                tick_us,
  output logic                tick_ms,
`ifdef TIMEBASE_SQUARE_EN
  output logic                timer_us,
  output logic                timer_ms,
`endif
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [1:0]          wr_mode,
  input  logic [N_CH-1:0]     ch_enable,
  input  logic [N_CH-1:0]     ch_clr,
  output logic [N_CH-1:0]     ch_pulse,
  output logic [N_CH-1:0]     ch_flag,
  output logic [N_CH-1:0]     ch_busy
);

  // Clock cycles per microsecond and the width of the prescaler counter.
  localparam int unsigned DIV   = CLK_HZ / 1_000_000;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned MS_W  = 10;

  // Elaboration-time parameter checks.
  if (DIV < 2) begin : g_chk_div
    $error("timebase_gen: CLK_HZ/1_000_000 must be >= 2");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_chk_nch
    $error("timebase_gen: N_CH must be in 1..16");
  end
  if (PERIOD_W < 1) begin : g_chk_pw
    $error("timebase_gen: PERIOD_W must be >= 1");
  end

  // Mode bit positions within wr_mode.
  localparam int unsigned MODE_PERIODIC = 0;
  localparam int unsigned MODE_MS_BASE  = 1;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // ---------------------------------------------------------------------------
  // Prescaler chain
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic             tick_us_q, tick_us_d;
  logic             tick_ms_q, tick_ms_d;

  // Next-state of the us divider and the ms divider that counts tick_us.
  // NOTE: every signal assigned in an always_comb gets a default on entry, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d     = cnt_q + DIV_W'(1);
    tick_us_d = 1'b0;
    if (cnt_q == DIV_W'(DIV - 1)) begin
      cnt_d     = '0;
      tick_us_d = 1'b1;
    end

    ms_cnt_d  = ms_cnt_q;
    tick_ms_d = 1'b0;
    if (tick_us_q) begin
      if (ms_cnt_q == MS_W'(999)) begin
        ms_cnt_d  = '0;
        tick_ms_d = 1'b1;
      end else begin
        ms_cnt_d = ms_cnt_q + MS_W'(1);
      end
    end
  end

  // Prescaler registers; the strobes are registered so they are glitch-free.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      ms_cnt_q  <= '0;
      tick_us_q <= 1'b0;
      tick_ms_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ms_cnt_q  <= ms_cnt_d;
      tick_us_q <= tick_us_d;
      tick_ms_q <= tick_ms_d;
    end
  end

  assign tick_us = tick_us_q;
  assign tick_ms = tick_ms_q;

`ifdef TIMEBASE_SQUARE_EN
  // ---------------------------------------------------------------------------
  // Square-wave compatibility outputs
  // ---------------------------------------------------------------------------
  logic timer_us_q;
  logic timer_ms_q;

  // Toggle on each strobe: periods of 2*DIV and 2000*DIV cycles.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      timer_us_q <= 1'b0;
      timer_ms_q <= 1'b0;
    end else begin
      if (tick_us_q) timer_us_q <= ~timer_us_q;
      if (tick_ms_q) timer_ms_q <= ~timer_ms_q;
    end
  end

  assign timer_us = timer_us_q;
  assign timer_ms = timer_ms_q;
`endif

  // ---------------------------------------------------------------------------
  // Countdown channels
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ch_state_e           state_q, state_d;
    logic [PERIOD_W-1:0] rem_q, rem_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [1:0]          mode_q, mode_d;
    logic                pulse_q, pulse_d;
    logic                flag_q, flag_d;
    logic                wr_sel;
    logic                base_tick;
    logic                expire;

    // A write addresses this channel only on an exact index match, so indices
    // at or above N_CH select nothing.
    assign wr_sel    = wr_en && (wr_ch == CH_W'(c));
    assign base_tick = mode_q[MODE_MS_BASE] ? tick_ms_q : tick_us_q;

    // Channel FSM next-state: a write overrides any expiry in the same cycle;
    // a disabled channel ignores its base tick (ticks are dropped, not queued).
    always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      period_d = period_q;
      mode_d   = mode_q;
      expire   = 1'b0;

      if (wr_sel) begin
        period_d = wr_period;
        mode_d   = wr_mode;
        rem_d    = wr_period;
        state_d  = (wr_period != '0) ? CH_RUN : CH_IDLE;
      end else begin
        case (state_q)
          CH_RUN: begin
            if (base_tick && ch_enable[c]) begin
              if (rem_q > PERIOD_W'(1)) begin
                rem_d = rem_q - PERIOD_W'(1);
              end else begin
                expire = 1'b1;
                if (mode_q[MODE_PERIODIC]) begin
                  rem_d = period_q;
                end else begin
                  state_d = CH_IDLE;
                end
              end
            end
          end
          default: begin
            state_d = CH_IDLE;
          end
        endcase
      end

      pulse_d = expire;
      // Setting the flag takes priority over a clear in the same cycle.
      if (expire) begin
        flag_d = 1'b1;
      end else if (ch_clr[c]) begin
        flag_d = 1'b0;
      end else begin
        flag_d = flag_q;
      end
    end

    // Channel state registers; reset leaves the channel idle with P=0, mode=0.
    always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
        state_q  <= CH_IDLE;
        rem_q    <= '0;
        period_q <= '0;
        mode_q   <= '0;
        pulse_q  <= 1'b0;
        flag_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        rem_q    <= rem_d;
        period_q <= period_d;
        mode_q   <= mode_d;
        pulse_q  <= pulse_d;
        flag_q   <= flag_d;
      end
    end

    assign ch_pulse[c] = pulse_q;
    assign ch_flag[c]  = flag_q;
    assign ch_busy[c]  = (state_q == CH_RUN);
  end

endmodule

// File: tb/tb_timebase_gen.sv
// Directed testbench for timebase_gen. Runs with CLK_HZ = 10 MHz (DIV = 10) so
// that millisecond-base behaviour fits in a short run. Cycle numbers below
// count rising edges since reset was released; outputs are sampled 1 ns after
// each edge.
module tb_timebase_gen;

  localparam int unsigned CLK_HZ   = 10_000_000;
  localparam int unsigned N_CH     = 4;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned CH_W     = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tick_us;
  logic                tick_ms;
`ifdef TIMEBASE_SQUARE_EN
  logic                timer_us;
  logic                timer_ms;
`endif
  logic                wr_en     = 1'b0;
  logic [CH_W-1:0]     wr_ch     = '0;
  logic [PERIOD_W-1:0] wr_period = '0;
  logic [1:0]          wr_mode   = '0;
  logic [N_CH-1:0]     ch_enable = '1;
  logic [N_CH-1:0]     ch_clr    = '0;
  logic [N_CH-1:0]     ch_pulse;
  logic [N_CH-1:0]     ch_flag;
  logic [N_CH-1:0]     ch_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int e       = 0;

  timebase_gen #(
    .CLK_HZ  (CLK_HZ),
    .N_CH    (N_CH),
    .PERIOD_W(PERIOD_W)
  ) dut (
    .CLK_50M  (clk),
    .RST      (rst),
    .tick_us  (tick_us),
    .tick_ms  (tick_ms),
`ifdef TIMEBASE_SQUARE_EN
    .timer_us (timer_us),
    .timer_ms (timer_ms),
`endif
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_period(wr_period),
    .wr_mode  (wr_mode),
    .ch_enable(ch_enable),
    .ch_clr   (ch_clr),
    .ch_pulse (ch_pulse),
    .ch_flag  (ch_flag),
    .ch_busy  (ch_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic goto(input int target);
    while (e < target) step();
  endtask

  // Drive a write for exactly one edge; it is captured at edge e+1.
  task automatic do_write(input int ch, input int p, input logic [1:0] mode);
    wr_en     = 1'b1;
    wr_ch     = CH_W'(ch);
    wr_period = PERIOD_W'(p);
    wr_mode   = mode;
    step();
    wr_en     = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_tick_us", tick_us, 0);
    check("rst_tick_ms", tick_ms, 0);
    check("rst_pulse", ch_pulse, 0);
    check("rst_flag", ch_flag, 0);
    check("rst_busy", ch_busy, 0);
    rst = 1'b0;
    e   = 0;

    // Prescaler: tick_us after edges 10, 20, ...
    goto(9);  check("tick_us_c9", tick_us, 0);
    goto(10); check("tick_us_c10", tick_us, 1);
    goto(11); check("tick_us_c11", tick_us, 0);
    goto(20); check("tick_us_c20", tick_us, 1);

    // ch0: P=3 periodic us base, written at edge 26; expiries at 51, 81
    goto(25); do_write(0, 3, 2'b01);
    check("ch0_busy_wr", ch_busy[0], 1);
    check("ch0_pulse_wr", ch_pulse[0], 0);
    goto(50); check("ch0_pulse_c50", ch_pulse[0], 0);
    goto(51); check("ch0_pulse_c51", ch_pulse[0], 1);
    check("ch0_flag_c51", ch_flag[0], 1);
    check("ch0_busy_c51", ch_busy[0], 1);
    goto(52); check("ch0_pulse_c52", ch_pulse[0], 0);
    goto(80); check("ch0_pulse_c80", ch_pulse[0], 0);
    goto(81); check("ch0_pulse_c81", ch_pulse[0], 1);

    // ch0 enable low over edges 86..105: ticks 91 and 101 lost, expiry 111 -> 131
    goto(85); ch_enable = 4'b1110;
    goto(95);  check("ch0_busy_dis", ch_busy[0], 1);
    goto(101); check("ch0_pulse_dis", ch_pulse[0], 0);
    goto(105); ch_enable = 4'b1111;
    goto(111); check("ch0_pulse_c111", ch_pulse[0], 0);
    goto(130); check("ch0_pulse_c130", ch_pulse[0], 0);
    goto(131); check("ch0_pulse_c131", ch_pulse[0], 1);

    // ch1: P=2 one-shot ms base, written at edge 136; ms ticks sampled at 10002, 20002
    goto(135); do_write(1, 2, 2'b10);
    check("ch1_busy_wr", ch_busy[1], 1);
    goto(10000); check("tick_ms_c10000", tick_ms, 0);
    goto(10001); check("tick_ms_c10001", tick_ms, 1);
    goto(10002); check("tick_ms_c10002", tick_ms, 0);
    check("ch1_pulse_c10002", ch_pulse[1], 0);
    goto(20001); check("ch1_pulse_c20001", ch_pulse[1], 0);
    check("ch1_busy_c20001", ch_busy[1], 1);
    goto(20002); check("ch1_pulse_c20002", ch_pulse[1], 1);
    check("ch1_flag_c20002", ch_flag[1], 1);
    check("ch1_busy_c20002", ch_busy[1], 0);
    goto(20003); check("ch1_pulse_c20003", ch_pulse[1], 0);
    goto(20010); check("ch1_flag_hold", ch_flag[1], 1);
    ch_clr = 4'b0010; step(); ch_clr = '0;
    check("ch1_flag_clr", ch_flag[1], 0);

    // ch2: P=1 periodic us base, written at edge 20016; expiry at 20021
    goto(20015); do_write(2, 1, 2'b01);
    goto(20020); check("ch2_pulse_c20020", ch_pulse[2], 0);
    goto(20021); check("ch2_pulse_c20021", ch_pulse[2], 1);
    check("ch2_flag_c20021", ch_flag[2], 1);
    goto(20025); ch_clr = 4'b0100; step(); ch_clr = '0;
    check("ch2_flag_clr", ch_flag[2], 0);
    // Rewrite captured on the expiry edge 20031: write wins
    goto(20030); do_write(2, 1, 2'b01);
    check("ch2_pulse_wr_exp", ch_pulse[2], 0);
    check("ch2_flag_wr_exp", ch_flag[2], 0);
    check("ch2_busy_wr_exp", ch_busy[2], 1);
    // Clear on the expiry edge 20041: set wins
    goto(20040); ch_clr = 4'b0100; step(); ch_clr = '0;
    check("ch2_pulse_clr_set", ch_pulse[2], 1);
    check("ch2_flag_clr_set", ch_flag[2], 1);
    goto(20042); check("ch2_flag_c20042", ch_flag[2], 1);
    // P=0 disarms
    goto(20045); do_write(2, 0, 2'b01);
    check("ch2_busy_p0", ch_busy[2], 0);
    goto(20051); check("ch2_pulse_p0", ch_pulse[2], 0);

    // ch0 rewrite while running: P=2 one-shot us at edge 20056 -> expiry 20071
    goto(20055); do_write(0, 2, 2'b00);
    check("ch0_busy_rewr", ch_busy[0], 1);
    goto(20061); check("ch0_pulse_c20061", ch_pulse[0], 0);
    goto(20062); do_write(3, 5, 2'b11);
    check("ch3_busy_wr", ch_busy[3], 1);
    goto(20071); check("ch0_pulse_c20071", ch_pulse[0], 1);
    check("ch0_busy_c20071", ch_busy[0], 0);
    goto(20081); check("ch0_pulse_c20081", ch_pulse[0], 0);

    // Reset mid-operation: async clear
    goto(20090);
    check("pre_rst_tick_us", tick_us, 1);
    check("pre_rst_flag", ch_flag, 4'b0101);
    check("pre_rst_busy", ch_busy, 4'b1000);
    rst = 1'b1;
    #1;
    check("mid_rst_tick_us", tick_us, 0);
    check("mid_rst_tick_ms", tick_ms, 0);
    check("mid_rst_pulse", ch_pulse, 0);
    check("mid_rst_flag", ch_flag, 0);
    check("mid_rst_busy", ch_busy, 0);
    repeat (3) step();
    rst = 1'b0;
    e   = 0;
    goto(9);  check("rel_tick_us_c9", tick_us, 0);
`ifdef TIMEBASE_SQUARE_EN
    check("sq_timer_us_c9", timer_us, 0);
`endif
    goto(10); check("rel_tick_us_c10", tick_us, 1);
    check("rel_busy", ch_busy, 0);
`ifdef TIMEBASE_SQUARE_EN
    check("sq_timer_us_c10", timer_us, 0);
    goto(11); check("sq_timer_us_c11", timer_us, 1);
    goto(20); check("sq_timer_us_c20", timer_us, 1);
    goto(21); check("sq_timer_us_c21", timer_us, 0);
    check("sq_timer_ms_c21", timer_ms, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
